// File: rtl/spi_ctrl_tx.sv
// spi_ctrl_tx: SPI mode-0 write-only initiator sending {1, addr[6:0], wdata[7:0]} MSB first; define SPI_CTRL_TX_FIFO_EN for a 2-entry request FIFO
module spi_ctrl_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       busy,
    output logic       done,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    state_t      state, state_n;
    logic [7:0]  div, div_n;
    logic [4:0]  bits, bits_n;
    logic [14:0] sh, sh_n;
    logic        sclk_n, copi_n, ncs_n, done_n;
    logic        pop;
    logic [14:0] head;
`ifdef SPI_CTRL_TX_FIFO_EN
    logic [1:0][14:0] fifo_q;
    logic [1:0]       cnt;
    logic             push;
    assign req_ready = (cnt != 2'd2) && rst_n;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (cnt != 2'd0);
    assign head      = fifo_q[0];
    assign busy      = (state != IDLE) || (cnt != 2'd0);
    // two-entry FIFO; entry 0 is always the head, a push while full is refused by req_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            fifo_q <= '0;
        end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (pop)
                fifo_q[0] <= (push && cnt == 2'd1) ? {req_addr, req_wdata} : fifo_q[1];
            else if (push && cnt == 2'd0)
                fifo_q[0] <= {req_addr, req_wdata};
            if (push && !pop && cnt == 2'd1)
                fifo_q[1] <= {req_addr, req_wdata};
        end
    end
`else
    assign req_ready = (state == IDLE) && rst_n;
    assign pop       = req_valid && req_ready;
    assign head      = {req_addr, req_wdata};
    assign busy      = state != IDLE;
`endif
    // next-state and next-pin values; the leading write bit is driven directly at load, sh keeps bits 14..0
    always_comb begin
        state_n = state;
        div_n   = div;
        bits_n  = bits;
        sh_n    = sh;
        sclk_n  = SCLK;
        copi_n  = COPI;
        ncs_n   = nCS;
        done_n  = 1'b0;
        case (state)
            IDLE: if (pop) begin
                state_n = SETUP;
                div_n   = DIV_LOAD;
                bits_n  = 5'd0;
                sh_n    = head;
                ncs_n   = 1'b0;
                copi_n  = 1'b1;
                sclk_n  = 1'b0;
            end
            SETUP, LOW: if (div == 8'd0) begin
                state_n = HIGH;
                sclk_n  = 1'b1;
                div_n   = DIV_LOAD;
            end else div_n = div - 8'd1;
            HIGH: if (div == 8'd0) begin
                state_n = (bits == 5'd15) ? HOLD : LOW;
                sclk_n  = 1'b0;
                div_n   = DIV_LOAD;
                bits_n  = bits + 5'd1;
                if (bits != 5'd15) begin
                    copi_n = sh[14];
                    sh_n   = {sh[13:0], 1'b0};
                end
            end else div_n = div - 8'd1;
            HOLD: if (div == 8'd0) begin
                state_n = GAP;
                div_n   = GAP_LOAD;
                ncs_n   = 1'b1;
                copi_n  = 1'b0;
                done_n  = 1'b1;
            end else div_n = div - 8'd1;
            GAP: if (div == 8'd0) state_n = IDLE;
                 else div_n = div - 8'd1;
            default: state_n = IDLE;
        endcase
    end
    // state, counters and all pin drivers are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div   <= 8'd0;
            bits  <= 5'd0;
            sh    <= 15'd0;
            SCLK  <= 1'b0;
            COPI  <= 1'b0;
            nCS   <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            div   <= div_n;
            bits  <= bits_n;
            sh    <= sh_n;
            SCLK  <= sclk_n;
            COPI  <= copi_n;
            nCS   <= ncs_n;
            done  <= done_n;
        end
    end
endmodule
